// File: rtl/rgb_gray_pipe.sv
// -----------------------------------------------------------------------------
// rgb_gray_pipe
//
// Pipelined colour-to-grey converter for the video front end (feeds the Sobel
// and Hough blocks). Each pixel is converted as
//   grey = sat( (kr*R + kg*G + kb*B + 2^(COEF_W-1)) >> COEF_W )
// or, in the single-channel modes, passes the selected channel straight through
// the same arithmetic. Data, syncs, enable and the pixel coordinates all leave
// the block exactly three clocks after they enter.
//
// Configuration (cfg_*) is shadowed on the rising edge of in_vsync, so a frame
// is always processed with one consistent set of weights/mode/ROI. A pixel that
// arrives on the vsync rising cycle already belongs to the new frame and uses
// the newly sampled configuration and y = 0.
//
// Optional feature macro: RGB_GRAY_ROI_MASK_EN
//   defined   : out_data is forced to 0 for pixels outside the ROI rectangle
//               [roi_x0..roi_x1] x [roi_y0..roi_y1]; an inverted range is empty.
//   undefined : ROI ports are accepted but ignored; no mask logic exists.
//
// Ports
//   clk, rst_n              pixel clock, asynchronous active-low reset
//   in_hsync/in_vsync/in_de input syncs and active-pixel enable
//   in_data [3*DW]          {R,G,B}, R in the MSBs
//   cfg_mode [2]            0 weighted, 1 R only, 2 G only, 3 B only
//   cfg_kr/kg/kb [COEF_W]   channel weights, COEF_W fractional bits
//   cfg_roi_x0/x1/y0/y1     inclusive ROI bounds
//   out_hsync/vsync/de      inputs delayed by 3 clocks
//   out_data [DW]           grey value (0 while out_de is low)
//   out_x / out_y [CW]      coordinate of the pixel on out_data
// -----------------------------------------------------------------------------
module rgb_gray_pipe #(
  parameter int DW     = 8,
  parameter int COEF_W = 8,
  parameter int H_DISP = 640,
  parameter int V_DISP = 480,
  parameter int CW     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic              in_de,
  input  logic [3*DW-1:0]   in_data,
  input  logic [1:0]        cfg_mode,
  input  logic [COEF_W-1:0] cfg_kr,
  input  logic [COEF_W-1:0] cfg_kg,
  input  logic [COEF_W-1:0] cfg_kb,
  input  logic [CW-1:0]     cfg_roi_x0,
  input  logic [CW-1:0]     cfg_roi_x1,
  input  logic [CW-1:0]     cfg_roi_y0,
  input  logic [CW-1:0]     cfg_roi_y1,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_de,
  output logic [DW-1:0]     out_data,
  output logic [CW-1:0]     out_x,
  output logic [CW-1:0]     out_y
);

  // Product, sum and rounded-sum widths. The sum of three products cannot
  // overflow SW bits; one extra bit keeps the rounding add exact.
  localparam int PW = DW + COEF_W;
  localparam int SW = DW + COEF_W + 2;
  localparam int RW = SW + 1;

  localparam logic [CW-1:0]     CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]     RND_HALF = {{(RW-1){1'b0}}, 1'b1} << (COEF_W - 1);
  localparam logic [RW-1:0]     GREY_MAX = {{(RW-DW){1'b0}}, {DW{1'b1}}};
  localparam logic [1:0]        MODE_RST = 2'd0;
  localparam logic [COEF_W-1:0] KR_RST   = COEF_W'(77);
  localparam logic [COEF_W-1:0] KG_RST   = COEF_W'(150);
  localparam logic [COEF_W-1:0] KB_RST   = COEF_W'(29);

  // Clamp the rounded/shifted sum into the output range.
  function automatic logic [DW-1:0] sat_grey(input logic [RW-1:0] v);
    logic [DW-1:0] r;
    if (v > GREY_MAX) begin
      r = {DW{1'b1}};
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Edge detection and configuration shadow
  // ---------------------------------------------------------------------------
  logic              vs_prev_r;
  logic              de_prev_r;
  logic              vs_rise_s;
  logic              de_fall_s;

  logic [1:0]        mode_r;
  logic [COEF_W-1:0] kr_r;
  logic [COEF_W-1:0] kg_r;
  logic [COEF_W-1:0] kb_r;

  logic [1:0]        mode_eff_s;
  logic [COEF_W-1:0] kr_eff_s;
  logic [COEF_W-1:0] kg_eff_s;
  logic [COEF_W-1:0] kb_eff_s;

  assign vs_rise_s = in_vsync & ~vs_prev_r;
  assign de_fall_s = ~in_de & de_prev_r;

  // Previous-cycle copies of vsync and de for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_r <= 1'b0;
      de_prev_r <= 1'b0;
    end else begin
      vs_prev_r <= in_vsync;
      de_prev_r <= in_de;
    end
  end

  // Weight/mode shadow, reloaded only at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= MODE_RST;
      kr_r   <= KR_RST;
      kg_r   <= KG_RST;
      kb_r   <= KB_RST;
    end else if (vs_rise_s) begin
      mode_r <= cfg_mode;
      kr_r   <= cfg_kr;
      kg_r   <= cfg_kg;
      kb_r   <= cfg_kb;
    end else begin
      mode_r <= mode_r;
      kr_r   <= kr_r;
      kg_r   <= kg_r;
      kb_r   <= kb_r;
    end
  end

  // The vsync-rise pixel belongs to the new frame, so it sees the new config.
  always_comb begin
    mode_eff_s = mode_r;
    kr_eff_s   = kr_r;
    kg_eff_s   = kg_r;
    kb_eff_s   = kb_r;
    if (vs_rise_s) begin
      mode_eff_s = cfg_mode;
      kr_eff_s   = cfg_kr;
      kg_eff_s   = cfg_kg;
      kb_eff_s   = cfg_kb;
    end else begin
      mode_eff_s = mode_r;
      kr_eff_s   = kr_r;
      kg_eff_s   = kg_r;
      kb_eff_s   = kb_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Coordinate counters
  // ---------------------------------------------------------------------------
  logic [CW-1:0] x_cnt_r;
  logic [CW-1:0] y_cnt_r;
  logic [CW-1:0] y_tag_s;

  // A pixel is tagged with the count before its own increment; on the vsync
  // rising cycle the y clear takes priority, so that pixel is row 0.
  assign y_tag_s = vs_rise_s ? {CW{1'b0}} : y_cnt_r;

  // Column counter: counts active pixels, cleared by any de-low cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_r <= {CW{1'b0}};
    end else if (in_de) begin
      if (x_cnt_r != CNT_MAX) begin
        x_cnt_r <= x_cnt_r + CNT_ONE;
      end else begin
        x_cnt_r <= x_cnt_r;
      end
    end else begin
      x_cnt_r <= {CW{1'b0}};
    end
  end

  // Row counter: counts de falling edges, cleared at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_cnt_r <= {CW{1'b0}};
    end else if (vs_rise_s) begin
      y_cnt_r <= {CW{1'b0}};
    end else if (de_fall_s && (y_cnt_r != CNT_MAX)) begin
      y_cnt_r <= y_cnt_r + CNT_ONE;
    end else begin
      y_cnt_r <= y_cnt_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional ROI: membership is decided in stage 1 (where the shadow and the
  // coordinate tag are both available) and carried down as a single bit.
  // ---------------------------------------------------------------------------
`ifdef RGB_GRAY_ROI_MASK_EN
  logic [CW-1:0] roi_x0_r;
  logic [CW-1:0] roi_x1_r;
  logic [CW-1:0] roi_y0_r;
  logic [CW-1:0] roi_y1_r;
  logic [CW-1:0] roi_x0_eff_s;
  logic [CW-1:0] roi_x1_eff_s;
  logic [CW-1:0] roi_y0_eff_s;
  logic [CW-1:0] roi_y1_eff_s;
  logic          roi_hit_s;
  logic          roi1_r;
  logic          roi2_r;

  // ROI shadow, reloaded only at frame start; resets to the full frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roi_x0_r <= {CW{1'b0}};
      roi_x1_r <= CW'(H_DISP - 1);
      roi_y0_r <= {CW{1'b0}};
      roi_y1_r <= CW'(V_DISP - 1);
    end else if (vs_rise_s) begin
      roi_x0_r <= cfg_roi_x0;
      roi_x1_r <= cfg_roi_x1;
      roi_y0_r <= cfg_roi_y0;
      roi_y1_r <= cfg_roi_y1;
    end else begin
      roi_x0_r <= roi_x0_r;
      roi_x1_r <= roi_x1_r;
      roi_y0_r <= roi_y0_r;
      roi_y1_r <= roi_y1_r;
    end
  end

  // Inclusive bounds test; an inverted range can never be satisfied.
  always_comb begin
    roi_x0_eff_s = roi_x0_r;
    roi_x1_eff_s = roi_x1_r;
    roi_y0_eff_s = roi_y0_r;
    roi_y1_eff_s = roi_y1_r;
    if (vs_rise_s) begin
      roi_x0_eff_s = cfg_roi_x0;
      roi_x1_eff_s = cfg_roi_x1;
      roi_y0_eff_s = cfg_roi_y0;
      roi_y1_eff_s = cfg_roi_y1;
    end else begin
      roi_x0_eff_s = roi_x0_r;
      roi_x1_eff_s = roi_x1_r;
      roi_y0_eff_s = roi_y0_r;
      roi_y1_eff_s = roi_y1_r;
    end
    roi_hit_s = (x_cnt_r >= roi_x0_eff_s) && (x_cnt_r <= roi_x1_eff_s) &&
                (y_tag_s >= roi_y0_eff_s) && (y_tag_s <= roi_y1_eff_s);
  end

  // ROI flag travelling alongside the pixel through stages 1 and 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roi1_r <= 1'b0;
      roi2_r <= 1'b0;
    end else begin
      roi1_r <= roi_hit_s;
      roi2_r <= roi1_r;
    end
  end
`else
  // ROI inputs are accepted but have no effect in this build.
  logic unused_roi_s;
  assign unused_roi_s = ^{cfg_roi_x0, cfg_roi_x1, cfg_roi_y0, cfg_roi_y1,
                          CW'(H_DISP), CW'(V_DISP)};
`endif

  // ---------------------------------------------------------------------------
  // Stage 1: per-channel products
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_s;
  logic [DW-1:0] g_s;
  logic [DW-1:0] b_s;
  logic [PW-1:0] p_r_s;
  logic [PW-1:0] p_g_s;
  logic [PW-1:0] p_b_s;

  assign r_s = in_data[3*DW-1 -: DW];
  assign g_s = in_data[2*DW-1 -: DW];
  assign b_s = in_data[DW-1:0];

  // Single-channel modes scale the chosen channel by 1.0 (a shift) so the
  // rest of the pipe is shared with the weighted mode.
  always_comb begin
    p_r_s = {PW{1'b0}};
    p_g_s = {PW{1'b0}};
    p_b_s = {PW{1'b0}};
    case (mode_eff_s)
      2'd0: begin
        p_r_s = PW'(kr_eff_s) * PW'(r_s);
        p_g_s = PW'(kg_eff_s) * PW'(g_s);
        p_b_s = PW'(kb_eff_s) * PW'(b_s);
      end
      2'd1: p_r_s = {r_s, {COEF_W{1'b0}}};
      2'd2: p_g_s = {g_s, {COEF_W{1'b0}}};
      2'd3: p_b_s = {b_s, {COEF_W{1'b0}}};
      default: begin
        p_r_s = {PW{1'b0}};
        p_g_s = {PW{1'b0}};
        p_b_s = {PW{1'b0}};
      end
    endcase
  end

  logic [PW-1:0] p_r1_r;
  logic [PW-1:0] p_g1_r;
  logic [PW-1:0] p_b1_r;
  logic          hs1_r;
  logic          vs1_r;
  logic          de1_r;
  logic [CW-1:0] x1_r;
  logic [CW-1:0] y1_r;

  // Stage 1 register: products plus the side-band that travels with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r1_r <= {PW{1'b0}};
      p_g1_r <= {PW{1'b0}};
      p_b1_r <= {PW{1'b0}};
      hs1_r  <= 1'b0;
      vs1_r  <= 1'b0;
      de1_r  <= 1'b0;
      x1_r   <= {CW{1'b0}};
      y1_r   <= {CW{1'b0}};
    end else begin
      p_r1_r <= p_r_s;
      p_g1_r <= p_g_s;
      p_b1_r <= p_b_s;
      hs1_r  <= in_hsync;
      vs1_r  <= in_vsync;
      de1_r  <= in_de;
      x1_r   <= x_cnt_r;
      y1_r   <= y_tag_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sum of products
  // ---------------------------------------------------------------------------
  logic [SW-1:0] sum_s;
  logic [SW-1:0] sum2_r;
  logic          hs2_r;
  logic          vs2_r;
  logic          de2_r;
  logic [CW-1:0] x2_r;
  logic [CW-1:0] y2_r;

  assign sum_s = SW'(p_r1_r) + SW'(p_g1_r) + SW'(p_b1_r);

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum2_r <= {SW{1'b0}};
      hs2_r  <= 1'b0;
      vs2_r  <= 1'b0;
      de2_r  <= 1'b0;
      x2_r   <= {CW{1'b0}};
      y2_r   <= {CW{1'b0}};
    end else begin
      sum2_r <= sum_s;
      hs2_r  <= hs1_r;
      vs2_r  <= vs1_r;
      de2_r  <= de1_r;
      x2_r   <= x1_r;
      y2_r   <= y1_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: round half up, saturate, blank/mask, register outputs
  // ---------------------------------------------------------------------------
  logic [RW-1:0] rounded_s;
  logic [RW-1:0] shifted_s;
  logic [DW-1:0] grey_s;

  assign rounded_s = {1'b0, sum2_r} + RND_HALF;
  assign shifted_s = rounded_s >> COEF_W;

  // Blanking has priority; the ROI mask only applies to active pixels.
  always_comb begin
    grey_s = {DW{1'b0}};
    if (!de2_r) begin
      grey_s = {DW{1'b0}};
`ifdef RGB_GRAY_ROI_MASK_EN
    end else if (!roi2_r) begin
      grey_s = {DW{1'b0}};
`endif
    end else begin
      grey_s = sat_grey(shifted_s);
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_de    <= 1'b0;
      out_data  <= {DW{1'b0}};
      out_x     <= {CW{1'b0}};
      out_y     <= {CW{1'b0}};
    end else begin
      out_hsync <= hs2_r;
      out_vsync <= vs2_r;
      out_de    <= de2_r;
      out_data  <= grey_s;
      out_x     <= x2_r;
      out_y     <= y2_r;
    end
  end

endmodule
